// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the rv32 memory-access stage: access widths, branch
// conditions, bus FSM states and the load extension helper.
package rv32_mem_pkg;

   localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'b00;
   localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'b01;
   localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'b10;

   localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'b00;
   localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'b01;
   localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'b10;
   localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'b11;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   // Widen a byte (half=0, value[7:0]) or half (half=1) to 32 bits.
   function automatic logic [31:0] extend_value(input logic [15:0] value,
                                                input logic        half,
                                                input logic        zero_extend);
      logic sign;
      if (half) begin
         sign = value[15] & ~zero_extend;
         return {{16{sign}}, value};
      end else begin
         sign = value[7] & ~zero_extend;
         return {{24{sign}}, value[7:0]};
      end
   endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// Combinational lane logic: store byte mask, store data replication and
// load lane selection with sign/zero extension.
module rv32_mem_align
   import rv32_mem_pkg::*;
(
   input  logic [1:0]  width,
   input  logic [1:0]  offset,
   input  logic        zero_extend,
   input  logic [31:0] store_value,
   input  logic [31:0] bus_value,
   output logic [3:0]  write_mask,
   output logic [31:0] write_value,
   output logic [31:0] load_value
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed lanes out of the bus word.
   always_comb begin
      byte_s = bus_value[7:0];
      case (offset)
         2'd0:    byte_s = bus_value[7:0];
         2'd1:    byte_s = bus_value[15:8];
         2'd2:    byte_s = bus_value[23:16];
         2'd3:    byte_s = bus_value[31:24];
         default: byte_s = bus_value[7:0];
      endcase
      if (offset[1]) begin
         half_s = bus_value[31:16];
      end else begin
         half_s = bus_value[15:0];
      end
   end

   // Width-dependent mask, replication and extension.
   always_comb begin
      write_mask  = 4'b0000;
      write_value = store_value;
      load_value  = bus_value;
      case (width)
         RV32_MEM_WIDTH_BYTE: begin
            write_mask  = 4'b0001 << offset;
            write_value = {4{store_value[7:0]}};
            load_value  = extend_value({8'h00, byte_s}, 1'b0, zero_extend);
         end
         RV32_MEM_WIDTH_HALF: begin
            write_mask  = offset[1] ? 4'b1100 : 4'b0011;
            write_value = {2{store_value[15:0]}};
            load_value  = extend_value(half_s, 1'b1, zero_extend);
         end
         RV32_MEM_WIDTH_WORD: begin
            write_mask  = 4'b1111;
            write_value = store_value;
            load_value  = bus_value;
         end
         default: begin
            write_mask  = 4'b0000;
            write_value = store_value;
            load_value  = bus_value;
         end
      endcase
   end

endmodule

// File: rtl/rv32_mem.sv
// rv32 memory-access stage: data-bus handshake, branch resolution and the
// pipeline register feeding writeback.
module rv32_mem
   import rv32_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall_in,
   input  logic        flush_in,
   input  logic        valid_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        mem_zero_extend_in,
   input  logic        mem_fence_in,
   input  logic [1:0]  mem_width_in,
   input  logic [1:0]  branch_op_in,
   input  logic        branch_predicted_taken_in,
   input  logic        alu_non_zero_in,
   input  logic [4:0]  rd_in,
   input  logic        rd_write_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] result_in,
   input  logic [31:0] rs2_value_in,
   input  logic [31:0] branch_pc_in,
   output logic [31:0] data_address_out,
   output logic        data_read_out,
   output logic        data_write_out,
   output logic [3:0]  data_write_mask_out,
   output logic [31:0] data_write_value_out,
   input  logic [31:0] data_read_value_in,
   input  logic        data_ready_in,
   output logic        stall_out,
   output logic        branch_mispredicted_out,
   output logic [31:0] branch_pc_out,
   output logic        valid_out,
   output logic        rd_write_out,
   output logic [4:0]  rd_out,
   output logic [31:0] rd_value_out
);

   mem_state_t  state_r;
   logic [31:0] hold_r;
   logic        access_s;
   logic        strobe_s;
   logic        taken_s;
   logic [31:0] load_value_s;
   logic [31:0] mem_value_s;
   logic        unused_s;

   // Fences need no bus activity in this stage.
   assign unused_s = mem_fence_in;

   rv32_mem_align u_align (
      .width       (mem_width_in),
      .offset      (result_in[1:0]),
      .zero_extend (mem_zero_extend_in),
      .store_value (rs2_value_in),
      .bus_value   (data_read_value_in),
      .write_mask  (data_write_mask_out),
      .write_value (data_write_value_out),
      .load_value  (load_value_s)
   );

   // Bus request; reset masks valid_in so nothing leaks out while held.
   always_comb begin
      access_s = valid_in & reset_n & (mem_read_in | mem_write_in);
      case (state_r)
         MEM_IDLE: strobe_s = access_s & ~flush_in;
         MEM_BUSY: strobe_s = access_s;
         MEM_DONE: strobe_s = 1'b0;
         default:  strobe_s = 1'b0;
      endcase
   end

   assign data_address_out = {result_in[31:2], 2'b00};
   assign data_read_out    = strobe_s & mem_read_in;
   assign data_write_out   = strobe_s & mem_write_in;
   assign stall_out        = strobe_s & ~data_ready_in;
   assign mem_value_s      = (state_r == MEM_DONE) ? hold_r : load_value_s;

   // Branch condition evaluation.
   always_comb begin
      case (branch_op_in)
         RV32_BRANCH_OP_NEVER:    taken_s = 1'b0;
         RV32_BRANCH_OP_ZERO:     taken_s = ~alu_non_zero_in;
         RV32_BRANCH_OP_NON_ZERO: taken_s = alu_non_zero_in;
         RV32_BRANCH_OP_ALWAYS:   taken_s = 1'b1;
         default:                 taken_s = 1'b0;
      endcase
   end

   assign branch_mispredicted_out = valid_in & reset_n & (taken_s != branch_predicted_taken_in);
   assign branch_pc_out           = taken_s ? branch_pc_in : pc_in + 32'd4;

   // Access FSM; DONE parks a completed access so it is never reissued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= MEM_IDLE;
         hold_r  <= 32'd0;
      end else begin
         case (state_r)
            MEM_IDLE: begin
               if (strobe_s) begin
                  if (data_ready_in) begin
                     hold_r  <= load_value_s;
                     state_r <= stall_in ? MEM_DONE : MEM_IDLE;
                  end else begin
                     state_r <= MEM_BUSY;
                  end
               end
            end
            MEM_BUSY: begin
               if (!access_s) begin
                  state_r <= MEM_IDLE;
               end else if (data_ready_in) begin
                  hold_r  <= load_value_s;
                  state_r <= stall_in ? MEM_DONE : MEM_IDLE;
               end
            end
            MEM_DONE: begin
               if (!stall_in) begin
                  state_r <= MEM_IDLE;
               end
            end
            default: state_r <= MEM_IDLE;
         endcase
      end
   end

   // Writeback pipeline register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_out    <= 1'b0;
         rd_write_out <= 1'b0;
         rd_out       <= 5'd0;
         rd_value_out <= 32'd0;
      end else if (!stall_in) begin
         valid_out    <= valid_in & ~flush_in;
         rd_write_out <= rd_write_in & ~flush_in;
         rd_out       <= rd_in;
         rd_value_out <= mem_read_in ? mem_value_s : result_in;
      end
   end

endmodule
